// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - decoder/flag inputs and datapath strobes of the 6502 cycle sequencer
interface cpu_sequencer_if;
  logic       rdy;
  logic [4:0] adr_mode;
  logic       to_mem;
  logic       branch_taken;
  logic       page_cross;
  logic [1:0] addr_sel;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_load;
  logic       latch_lo;
  logic       latch_hi;
  logic       mem_we;
  logic       exec;
  logic       sync;
  logic [2:0] tstate;
  logic       halt;

  modport slave (
    input  rdy, adr_mode, to_mem, branch_taken, page_cross,
    output addr_sel, ir_load, pc_inc, pc_load, latch_lo, latch_hi,
           mem_we, exec, sync, tstate, halt
  );

  modport master (
    output rdy, adr_mode, to_mem, branch_taken, page_cross,
    input  addr_sel, ir_load, pc_inc, pc_load, latch_lo, latch_hi,
           mem_we, exec, sync, tstate, halt
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - T-state sequencer for the non-stack 6502 addressing modes
`ifndef ADR_IMPL
`define ADR_IMPL      5'd0
`endif
`ifndef ADR_ACCUM
`define ADR_ACCUM     5'd1
`endif
`ifndef ADR_IMM
`define ADR_IMM       5'd2
`endif
`ifndef ADR_ZPG
`define ADR_ZPG       5'd3
`endif
`ifndef ADR_ABS
`define ADR_ABS       5'd4
`endif
`ifndef ADR_ABS_JMP
`define ADR_ABS_JMP   5'd5
`endif
`ifndef ADR_ZPG_X_Y
`define ADR_ZPG_X_Y   5'd6
`endif
`ifndef ADR_ABS_X_Y
`define ADR_ABS_X_Y   5'd7
`endif
`ifndef ADR_ZPG_RMW
`define ADR_ZPG_RMW   5'd8
`endif
`ifndef ADR_ABS_RMW
`define ADR_ABS_RMW   5'd9
`endif
`ifndef ADR_ZPG_X_RMW
`define ADR_ZPG_X_RMW 5'd10
`endif
`ifndef ADR_ABS_X_RMW
`define ADR_ABS_X_RMW 5'd11
`endif
`ifndef ADR_REL
`define ADR_REL       5'd12
`endif

module cpu_sequencer (
  input  logic            clk,
  input  logic            rst,
  cpu_sequencer_if.slave  bus
);
  localparam logic [1:0] SEL_PC  = 2'd0;
  localparam logic [1:0] SEL_ZPG = 2'd1;
  localparam logic [1:0] SEL_ABS = 2'd2;
  localparam logic [1:0] SEL_EFF = 2'd3;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  state_t     state;
  logic [2:0] tstate_q;

  logic [1:0] sel;
  logic       ir, inc, ld, lo, hi, we, ex, sync_c, last, bad;

  always_comb begin
    sel = SEL_PC; ir = 1'b0; inc = 1'b0; ld = 1'b0; lo = 1'b0; hi = 1'b0;
    we = 1'b0; ex = 1'b0; sync_c = 1'b0; last = 1'b0; bad = 1'b0;
    case (state)
      S_FETCH: begin
        sync_c = 1'b1; ir = 1'b1; inc = 1'b1;
      end
      S_EXEC: begin
        case (bus.adr_mode)
          `ADR_IMPL, `ADR_ACCUM: begin
            ex = 1'b1; last = 1'b1;
          end
          `ADR_IMM: begin
            inc = 1'b1; ex = 1'b1; last = 1'b1;
          end
          `ADR_ZPG: case (tstate_q)
            3'd1:    begin lo = 1'b1; inc = 1'b1; end
            default: begin sel = SEL_ZPG; we = bus.to_mem; ex = 1'b1; last = 1'b1; end
          endcase
          `ADR_ABS: case (tstate_q)
            3'd1:    begin lo = 1'b1; inc = 1'b1; end
            3'd2:    begin hi = 1'b1; inc = 1'b1; end
            default: begin sel = SEL_ABS; we = bus.to_mem; ex = 1'b1; last = 1'b1; end
          endcase
          `ADR_ABS_JMP: case (tstate_q)
            3'd1:    begin lo = 1'b1; inc = 1'b1; end
            default: begin hi = 1'b1; ld = 1'b1; last = 1'b1; end
          endcase
          `ADR_ZPG_X_Y: case (tstate_q)
            3'd1:    begin lo = 1'b1; inc = 1'b1; end
            3'd2:    sel = SEL_ZPG;
            default: begin sel = SEL_EFF; we = bus.to_mem; ex = 1'b1; last = 1'b1; end
          endcase
          // Loads without a page cross finish at T3; stores always take the fix-up cycle.
          `ADR_ABS_X_Y: case (tstate_q)
            3'd1: begin lo = 1'b1; inc = 1'b1; end
            3'd2: begin hi = 1'b1; inc = 1'b1; end
            3'd3: begin
              sel = SEL_EFF;
              if (!bus.page_cross && !bus.to_mem) begin
                ex = 1'b1; last = 1'b1;
              end
            end
            default: begin sel = SEL_EFF; we = bus.to_mem; ex = 1'b1; last = 1'b1; end
          endcase
          `ADR_ZPG_RMW: case (tstate_q)
            3'd1:    begin lo = 1'b1; inc = 1'b1; end
            3'd2:    sel = SEL_ZPG;
            3'd3:    begin sel = SEL_ZPG; we = 1'b1; end
            default: begin sel = SEL_ZPG; we = 1'b1; ex = 1'b1; last = 1'b1; end
          endcase
          `ADR_ABS_RMW: case (tstate_q)
            3'd1:    begin lo = 1'b1; inc = 1'b1; end
            3'd2:    begin hi = 1'b1; inc = 1'b1; end
            3'd3:    sel = SEL_ABS;
            3'd4:    begin sel = SEL_ABS; we = 1'b1; end
            default: begin sel = SEL_ABS; we = 1'b1; ex = 1'b1; last = 1'b1; end
          endcase
          `ADR_ZPG_X_RMW: case (tstate_q)
            3'd1:    begin lo = 1'b1; inc = 1'b1; end
            3'd2:    sel = SEL_ZPG;
            3'd3:    sel = SEL_EFF;
            3'd4:    begin sel = SEL_EFF; we = 1'b1; end
            default: begin sel = SEL_EFF; we = 1'b1; ex = 1'b1; last = 1'b1; end
          endcase
          `ADR_ABS_X_RMW: case (tstate_q)
            3'd1:       begin lo = 1'b1; inc = 1'b1; end
            3'd2:       begin hi = 1'b1; inc = 1'b1; end
            3'd3, 3'd4: sel = SEL_EFF;
            3'd5:       begin sel = SEL_EFF; we = 1'b1; end
            default:    begin sel = SEL_EFF; we = 1'b1; ex = 1'b1; last = 1'b1; end
          endcase
          `ADR_REL: case (tstate_q)
            3'd1: begin
              lo = 1'b1; inc = 1'b1; last = !bus.branch_taken;
            end
            3'd2:    begin ld = 1'b1; last = !bus.page_cross; end
            default: begin ld = 1'b1; last = 1'b1; end
          endcase
          default: bad = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FETCH;
      tstate_q <= 3'd0;
    end else if (bus.rdy) begin
      case (state)
        S_FETCH: begin
          state    <= S_EXEC;
          tstate_q <= 3'd1;
        end
        S_EXEC: begin
          if (bad) begin
            state <= S_HALT;
          end else if (last) begin
            state    <= S_FETCH;
            tstate_q <= 3'd0;
          end else begin
            tstate_q <= tstate_q + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // rst is folded in so the strobes stay quiet while reset is held in FETCH.
  logic en;
  assign en = bus.rdy & ~rst;

  assign bus.addr_sel = sel;
  assign bus.sync     = sync_c;
  assign bus.ir_load  = ir  & en;
  assign bus.pc_inc   = inc & en;
  assign bus.pc_load  = ld  & en;
  assign bus.latch_lo = lo  & en;
  assign bus.latch_hi = hi  & en;
  assign bus.mem_we   = we  & en;
  assign bus.exec     = ex  & en;
  assign bus.tstate   = tstate_q;
  assign bus.halt     = (state == S_HALT) | bad;
endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
  localparam logic [4:0] M_ABS     = 5'd4;
  localparam logic [4:0] M_ABS_JMP = 5'd5;
  localparam logic [4:0] M_ABS_X_Y = 5'd7;
  localparam logic [4:0] M_ZPG_RMW = 5'd8;
  localparam logic [4:0] M_REL     = 5'd12;
  localparam logic [4:0] M_INVAL   = 5'd31;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  cpu_sequencer_if bus();
  cpu_sequencer dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  // {addr_sel, ir_load, pc_inc, pc_load, latch_lo, latch_hi, mem_we, exec, sync, halt, tstate}
  function automatic logic [14:0] e(input logic [1:0] sel, input logic ir, input logic inc,
                                    input logic ld, input logic lo, input logic hi,
                                    input logic we, input logic ex, input logic sy,
                                    input logic hl, input logic [2:0] ts);
    return {sel, ir, inc, ld, lo, hi, we, ex, sy, hl, ts};
  endfunction

  task automatic cyc(input string tag, input logic [14:0] exp);
    logic [14:0] obs;
    @(negedge clk);
    obs = {bus.addr_sel, bus.ir_load, bus.pc_inc, bus.pc_load, bus.latch_lo, bus.latch_hi,
           bus.mem_we, bus.exec, bus.sync, bus.halt, bus.tstate};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  logic [14:0] v_rst, v_f, v_op_lo, v_op_hi, v_none;

  initial begin
    v_rst   = e(0,0,0,0,0,0,0,0,1,0,0);
    v_f     = e(0,1,1,0,0,0,0,0,1,0,0);
    v_op_lo = e(0,0,1,0,1,0,0,0,0,0,1);
    v_op_hi = e(0,0,1,0,0,1,0,0,0,0,2);
    bus.rdy = 1'b1; bus.adr_mode = M_ABS; bus.to_mem = 1'b0;
    bus.branch_taken = 1'b0; bus.page_cross = 1'b0;

    cyc("reset_state", v_rst);
    rst = 1'b0;

    // LDA abs
    cyc("lda_abs_f", v_f);
    cyc("lda_abs_t1", v_op_lo);
    cyc("lda_abs_t2", v_op_hi);
    cyc("lda_abs_t3", e(2,0,0,0,0,0,0,1,0,0,3));
    cyc("lda_abs_next_f", v_f);
    cyc("lda_abs2_t1", v_op_lo);
    cyc("lda_abs2_t2", v_op_hi);
    cyc("lda_abs2_t3", e(2,0,0,0,0,0,0,1,0,0,3));

    // LDA abs,X no cross
    bus.adr_mode = M_ABS_X_Y;
    cyc("ldax_nc_f", v_f);
    cyc("ldax_nc_t1", v_op_lo);
    cyc("ldax_nc_t2", v_op_hi);
    cyc("ldax_nc_t3", e(3,0,0,0,0,0,0,1,0,0,3));
    // LDA abs,X with cross; page_cross dropped in T4 must not matter
    cyc("ldax_c_f", v_f);
    cyc("ldax_c_t1", v_op_lo);
    cyc("ldax_c_t2", v_op_hi);
    bus.page_cross = 1'b1;
    cyc("ldax_c_t3", e(3,0,0,0,0,0,0,0,0,0,3));
    bus.page_cross = 1'b0;
    cyc("ldax_c_t4", e(3,0,0,0,0,0,0,1,0,0,4));
    // STA abs,X no cross
    bus.to_mem = 1'b1;
    cyc("stax_f", v_f);
    cyc("stax_t1", v_op_lo);
    cyc("stax_t2", v_op_hi);
    cyc("stax_t3", e(3,0,0,0,0,0,0,0,0,0,3));
    cyc("stax_t4", e(3,0,0,0,0,0,1,1,0,0,4));
    bus.to_mem = 1'b0;

    // INC zpg
    bus.adr_mode = M_ZPG_RMW;
    cyc("inc_zpg_f", v_f);
    cyc("inc_zpg_t1", v_op_lo);
    cyc("inc_zpg_t2", e(1,0,0,0,0,0,0,0,0,0,2));
    cyc("inc_zpg_t3", e(1,0,0,0,0,0,1,0,0,0,3));
    cyc("inc_zpg_t4", e(1,0,0,0,0,0,1,1,0,0,4));

    // BNE not taken / taken / taken with cross
    bus.adr_mode = M_REL;
    cyc("bne_nt_f", v_f);
    cyc("bne_nt_t1", v_op_lo);
    cyc("bne_t_f", v_f);
    bus.branch_taken = 1'b1;
    cyc("bne_t_t1", v_op_lo);
    bus.branch_taken = 1'b0;
    cyc("bne_t_t2", e(0,0,0,1,0,0,0,0,0,0,2));
    cyc("bne_tc_f", v_f);
    bus.branch_taken = 1'b1;
    cyc("bne_tc_t1", v_op_lo);
    bus.branch_taken = 1'b0; bus.page_cross = 1'b1;
    cyc("bne_tc_t2", e(0,0,0,1,0,0,0,0,0,0,2));
    bus.page_cross = 1'b0;
    cyc("bne_tc_t3", e(0,0,0,1,0,0,0,0,0,0,3));

    // JMP abs
    bus.adr_mode = M_ABS_JMP;
    cyc("jmp_f", v_f);
    cyc("jmp_t1", v_op_lo);
    cyc("jmp_t2", e(0,0,0,1,0,1,0,0,0,0,2));

    // rdy stall in ABS T2
    bus.adr_mode = M_ABS;
    cyc("stall_f", v_f);
    cyc("stall_t1", v_op_lo);
    bus.rdy = 1'b0;
    v_none = e(0,0,0,0,0,0,0,0,0,0,2);
    for (int i = 0; i < 3; i++) cyc("stall_hold", v_none);
    bus.rdy = 1'b1;
    cyc("stall_t2", v_op_hi);
    cyc("stall_t3", e(2,0,0,0,0,0,0,1,0,0,3));
    cyc("stall_next_f", v_f);

    // reset mid-instruction during ABS T2
    cyc("rstmid_t1", v_op_lo);
    rst = 1'b1;
    cyc("rstmid_async", v_rst);
    cyc("rstmid_hold", v_rst);
    rst = 1'b0;
    cyc("rstmid_first_f", v_f);
    cyc("rstmid_t1b", v_op_lo);
    cyc("rstmid_t2b", v_op_hi);
    cyc("rstmid_t3b", e(2,0,0,0,0,0,0,1,0,0,3));

    // invalid mode traps until reset
    bus.adr_mode = M_INVAL;
    cyc("inval_f", v_f);
    for (int i = 0; i < 4; i++) cyc("inval_halt", e(0,0,0,0,0,0,0,0,0,1,1));
    bus.adr_mode = M_ABS;
    cyc("inval_stuck", e(0,0,0,0,0,0,0,0,0,1,1));
    rst = 1'b1;
    cyc("inval_rst", v_rst);
    rst = 1'b0;
    cyc("inval_recover_f", v_f);
    cyc("inval_recover_t1", v_op_lo);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
